// File: rtl/iface_master.sv
// Command-to-target bridge: one outstanding write or read at a time,
// with a rdy timeout and a held response channel.
`timescale 1ns/1ps
module iface_master #(
  parameter int TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic       cmd_wdata,
  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,
  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_write,
  output logic       rsp_data,
  output logic       rsp_err,
  output logic [7:0] txn_count,
  output logic [3:0] err_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  logic [1:0] state_q, state_d;
  logic       wr_q, wr_d;
  logic [2:0] addr_q, addr_d;
  logic       wdata_q, wdata_d;
  logic [7:0] wait_q, wait_d;
  logic       rdata_q, rdata_d;
  logic       err_q, err_d;
  logic [7:0] txn_q, txn_d;
  logic [3:0] errc_q, errc_d;
  logic       fire;

  assign cmd_ready     = (state_q == IDLE);
  assign write_en      = (state_q == WR) & write_rdy;
  assign read_en       = (state_q == RD) & read_rdy;
  assign fire          = write_en | read_en;
  assign write_address = addr_q;
  assign read_address  = addr_q;
  assign write_data    = wdata_q;
  assign rsp_valid     = (state_q == RSP);
  assign rsp_write     = wr_q;
  assign rsp_data      = rdata_q;
  assign rsp_err       = err_q;
  assign txn_count     = txn_q;
  assign err_count     = errc_q;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    txn_d   = txn_q;
    errc_d  = errc_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wait_d  = 8'd0;
          state_d = cmd_write ? WR : RD;
        end
      end
      WR, RD: begin
        // a fire in the last allowed cycle wins over the abort
        if (fire) begin
          state_d = RSP;
          err_d   = 1'b0;
          rdata_d = (state_q == RD) ? read_data : 1'b0;
          txn_d   = txn_q + 8'd1;
        end else if (wait_q == 8'(TIMEOUT)) begin
          state_d = RSP;
          err_d   = 1'b1;
          rdata_d = 1'b0;
          if (errc_q != 4'hf) errc_d = errc_q + 4'd1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 3'd0;
      wdata_q <= 1'b0;
      wait_q  <= 8'd0;
      rdata_q <= 1'b0;
      err_q   <= 1'b0;
      txn_q   <= 8'd0;
      errc_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
      errc_q  <= errc_d;
    end
  end

endmodule

// File: tb/tb_iface_master.sv
// Bench for iface_master: scoreboard of expected responses,
// one task per scenario.
`timescale 1ns/1ps
module tb_iface_master;

  localparam int TMO = 15;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [2:0] cmd_addr = 3'd0;
  logic       cmd_wdata = 1'b0;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy = 1'b0;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data = 1'b0;
  logic       read_rdy = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_write;
  logic       rsp_data;
  logic       rsp_err;
  logic [7:0] txn_count;
  logic [3:0] err_count;

  int errors = 0;
  int checks = 0;
  int exp_txn = 0;
  int exp_err = 0;
  logic [2:0] sb[$];

  iface_master #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  // delay < 0: target never ready
  task automatic run_txn(input bit w, input logic [2:0] a,
                         input bit d, input int delay,
                         input bit rdata, input int stall);
    logic [2:0] exp;
    logic [2:0] held;
    int cyc;
    int en_cnt;
    bit abort;
    bit rdy;
    abort = (delay < 0) || (delay > TMO);
    @(negedge CLK);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    if (abort) begin
      sb.push_back({w, 1'b0, 1'b1});
      if (exp_err < 15) exp_err++;
    end else begin
      sb.push_back({w, w ? 1'b0 : rdata, 1'b0});
      exp_txn = (exp_txn + 1) % 256;
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    cyc = 0;
    en_cnt = 0;
    while (rsp_valid !== 1'b1 && cyc < 40) begin
      rdy = (delay >= 0) && (cyc >= delay);
      write_rdy = w & rdy;
      read_rdy = ~w & rdy;
      read_data = rdata;
      #1;
      if (write_en === 1'b1 || read_en === 1'b1) begin
        en_cnt++;
        checks++;
        if ({write_en, read_en, write_address, read_address, write_data}
            !== {w, ~w, a, a, d}) begin
          errors++;
          $display("FAIL fire_outputs got %b exp %b",
            {write_en, read_en, write_address, read_address, write_data},
            {w, ~w, a, a, d});
        end
      end
      @(negedge CLK);
      cyc++;
    end
    write_rdy = 1'b0; read_rdy = 1'b0; read_data = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout got rsp_valid %b exp 1", rsp_valid);
    end
    checks++;
    if (cyc != (abort ? TMO + 1 : delay + 1)) begin
      errors++;
      $display("FAIL busy_cycles got %0d exp %0d",
        cyc, abort ? TMO + 1 : delay + 1);
    end
    checks++;
    if (en_cnt != (abort ? 0 : 1)) begin
      errors++;
      $display("FAIL enable_cycles got %0d exp %0d",
        en_cnt, abort ? 0 : 1);
    end
    held = {rsp_write, rsp_data, rsp_err};
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1; cmd_write = ~w; cmd_addr = ~a;
      write_rdy = 1'b1; read_rdy = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, cmd_ready, write_en, read_en,
           rsp_write, rsp_data, rsp_err} !== {4'b1000, held}) begin
        errors++;
        $display("FAIL rsp_hold got %b exp %b",
          {rsp_valid, cmd_ready, write_en, read_en,
           rsp_write, rsp_data, rsp_err}, {4'b1000, held});
      end
      @(negedge CLK);
    end
    cmd_valid = 1'b0; write_rdy = 1'b0; read_rdy = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty got 0 entries exp 1");
    end else begin
      exp = sb.pop_front();
      if ({rsp_write, rsp_data, rsp_err} !== exp) begin
        errors++;
        $display("FAIL rsp_fields got %b exp %b",
          {rsp_write, rsp_data, rsp_err}, exp);
      end
    end
    @(negedge CLK);
    rsp_ready = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid, txn_count, err_count}
        !== {1'b1, 1'b0, 8'(exp_txn), 4'(exp_err)}) begin
      errors++;
      $display("FAIL post_rsp got rdy %b v %b txn %0d err %0d exp 1 0 %0d %0d",
        cmd_ready, rsp_valid, txn_count, err_count, exp_txn, exp_err);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    write_rdy = 1'b1; read_rdy = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({cmd_ready, write_en, read_en, rsp_valid, rsp_write, rsp_data,
         rsp_err, write_address, read_address, write_data, txn_count,
         err_count} !== {1'b1, 6'b0, 3'd0, 3'd0, 1'b0, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state got %b %b %b %b %0d %0d",
        cmd_ready, write_en, read_en, rsp_valid, txn_count, err_count);
    end
    write_rdy = 1'b0; read_rdy = 1'b0;
    RST_N = 1'b1;
    exp_txn = 0; exp_err = 0;
    sb.delete();
  endtask

  task automatic test_write();
    run_txn(1'b1, 3'd5, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_read_wait();
    run_txn(1'b0, 3'd3, 1'b0, 4, 1'b1, 0);
    run_txn(1'b0, 3'd1, 1'b1, 0, 1'b0, 0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'd2, 1'b0, TMO, 1'b1, 0);
    run_txn(1'b0, 3'd2, 1'b0, -1, 1'b1, 0);
    run_txn(1'b1, 3'd4, 1'b1, TMO + 1, 1'b0, 0);
    for (int i = 0; i < 16; i++)
      run_txn(i[0], 3'(i), 1'b1, -1, 1'b1, 0);
    checks++;
    if (err_count !== 4'd15) begin
      errors++;
      $display("FAIL err_saturate got %0d exp 15", err_count);
    end
  endtask

  task automatic test_backpressure();
    run_txn(1'b1, 3'd6, 1'b0, 2, 1'b0, 5);
    run_txn(1'b0, 3'd7, 1'b0, 1, 1'b1, 3);
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    write_rdy = 1'b1;
    #1;
    checks++;
    if (write_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_wr_en got %b exp 1", write_en);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({write_en, read_en, rsp_valid, cmd_ready, txn_count, err_count}
        !== {4'b0001, 8'd0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset got en %b rv %b rdy %b txn %0d err %0d exp 0 0 1 0 0",
        write_en, rsp_valid, cmd_ready, txn_count, err_count);
    end
    write_rdy = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    exp_txn = 0; exp_err = 0;
    sb.delete();
    run_txn(1'b0, 3'd5, 1'b0, 0, 1'b1, 0);
  endtask

  task automatic test_wrap();
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    exp_txn = 0; exp_err = 0;
    sb.delete();
    for (int i = 0; i < 256; i++)
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 0);
    checks++;
    if (txn_count !== 8'd0) begin
      errors++;
      $display("FAIL txn_wrap got %0d exp 0", txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
